// File: rtl/menu_button_link_ctrl.sv
// Menu front end: hover hit-testing for the Start/Connect buttons, press/release
// click pulses, and the two-board connect handshake driving send/receive_connect.
module menu_button_link_ctrl #(
  parameter int START_X0       = 240,
  parameter int START_X1       = 399,
  parameter int START_Y0       = 230,
  parameter int START_Y1       = 289,
  parameter int CONN_X0        = 240,
  parameter int CONN_X1        = 399,
  parameter int CONN_Y0        = 330,
  parameter int CONN_Y1        = 389,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       MOUSE_LEFT,
  input  logic       link_in,
  output logic       link_out,
  output logic       mouse_on_start_button,
  output logic       mouse_on_connect_button,
  output logic       start_click,
  output logic       send_connect,
  output logic       receive_connect,
  output logic       link_up
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SENDING, CONNECTED} state_t;

  state_t        state, next_state;
  logic          in_start, in_conn;
  logic          left_q, prs_edge, rel_edge;
  logic          arm_start, arm_conn, conn_click;
  logic          sync1, sync2;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign in_start = (mouse_x >= 10'(START_X0)) && (mouse_x <= 10'(START_X1)) &&
                    (mouse_y >= 10'(START_Y0)) && (mouse_y <= 10'(START_Y1));
  assign in_conn  = (mouse_x >= 10'(CONN_X0))  && (mouse_x <= 10'(CONN_X1))  &&
                    (mouse_y >= 10'(CONN_Y0))  && (mouse_y <= 10'(CONN_Y1));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mouse_on_start_button   <= 1'b0;
      mouse_on_connect_button <= 1'b0;
    end else begin
      mouse_on_start_button   <= in_start;
      mouse_on_connect_button <= in_conn;
    end

  assign prs_edge = MOUSE_LEFT & ~left_q;
  assign rel_edge = ~MOUSE_LEFT & left_q;

  // left_q resets high so a button still held across reset is not seen as a press.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      left_q      <= 1'b1;
      arm_start   <= 1'b0;
      arm_conn    <= 1'b0;
      start_click <= 1'b0;
      conn_click  <= 1'b0;
    end else begin
      left_q      <= MOUSE_LEFT;
      start_click <= 1'b0;
      conn_click  <= 1'b0;
      if (prs_edge) begin
        arm_start <= mouse_on_start_button;
        arm_conn  <= mouse_on_connect_button;
      end else if (rel_edge) begin
        start_click <= arm_start & mouse_on_start_button;
        conn_click  <= arm_conn & mouse_on_connect_button;
        arm_start   <= 1'b0;
        arm_conn    <= 1'b0;
      end
    end

  // Remote request: 2-FF synchronizer, then follow only after STABLE_CYCLES differing cycles.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1           <= 1'b0;
      sync2           <= 1'b0;
      stab_cnt        <= '0;
      receive_connect <= 1'b0;
    end else begin
      sync1 <= link_in;
      sync2 <= sync1;
      if (sync2 == receive_connect)
        stab_cnt <= '0;
      else if (stab_cnt == SW'(STABLE_CYCLES - 1)) begin
        receive_connect <= sync2;
        stab_cnt        <= '0;
      end else
        stab_cnt <= stab_cnt + 1'b1;
    end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // A cancel click beats a simultaneous remote acceptance.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (conn_click) next_state = SENDING;
      SENDING:   if (conn_click)           next_state = IDLE;
                 else if (receive_connect) next_state = CONNECTED;
                 else if (tmo_hit)         next_state = IDLE;
      CONNECTED: if (conn_click)            next_state = IDLE;
                 else if (!receive_connect) next_state = SENDING;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      send_connect <= 1'b0;
      link_out     <= 1'b0;
      link_up      <= 1'b0;
    end else begin
      state        <= next_state;
      tmo_cnt      <= (state == SENDING && next_state == SENDING) ? tmo_cnt + 1'b1 : '0;
      send_connect <= (next_state != IDLE);
      link_out     <= (next_state != IDLE);
      link_up      <= (next_state == CONNECTED);
    end

endmodule

// File: tb/tb_menu_button_link_ctrl.sv
// Directed bench for menu_button_link_ctrl: hover, clicks, debounce, handshake, timeout, reset.
module tb_menu_button_link_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] mouse_x, mouse_y;
  logic       MOUSE_LEFT, link_in;
  logic       link_out, mouse_on_start_button, mouse_on_connect_button;
  logic       start_click, send_connect, receive_connect, link_up;
  int         total = 0;
  int         bad = 0;

  menu_button_link_ctrl #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .MOUSE_LEFT(MOUSE_LEFT), .link_in(link_in), .link_out(link_out),
    .mouse_on_start_button(mouse_on_start_button),
    .mouse_on_connect_button(mouse_on_connect_button),
    .start_click(start_click), .send_connect(send_connect),
    .receive_connect(receive_connect), .link_up(link_up));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_lo"}, {31'd0, link_out}, 0);
    chk({tag, "_hs"}, {31'd0, mouse_on_start_button}, 0);
    chk({tag, "_hc"}, {31'd0, mouse_on_connect_button}, 0);
    chk({tag, "_sc"}, {31'd0, start_click}, 0);
    chk({tag, "_snd"}, {31'd0, send_connect}, 0);
    chk({tag, "_rcv"}, {31'd0, receive_connect}, 0);
    chk({tag, "_up"}, {31'd0, link_up}, 0);
  endtask

  // Hover, press, release; returns just after the edge that raises the click pulse.
  task automatic click(input logic [9:0] x, input logic [9:0] y);
    mouse_x = x; mouse_y = y;
    tick();
    MOUSE_LEFT = 1'b1;
    tick();
    MOUSE_LEFT = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; MOUSE_LEFT = 1'b0; link_in = 1'b0; mouse_x = '0; mouse_y = '0;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;
    tick();

    // hover, including inclusive corners and the first column/row outside
    mouse_x = 240; mouse_y = 230; tick();
    chk("hov_start_corner", {31'd0, mouse_on_start_button}, 1);
    chk("hov_conn_off", {31'd0, mouse_on_connect_button}, 0);
    mouse_x = 400; tick();
    chk("hov_start_x400", {31'd0, mouse_on_start_button}, 0);
    mouse_x = 300; mouse_y = 389; tick();
    chk("hov_conn_y389", {31'd0, mouse_on_connect_button}, 1);
    chk("hov_start_off", {31'd0, mouse_on_start_button}, 0);
    mouse_y = 390; tick();
    chk("hov_conn_y390", {31'd0, mouse_on_connect_button}, 0);

    // start click with a 5-cycle hold
    mouse_x = 300; mouse_y = 250; tick();
    MOUSE_LEFT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sc_hold", {31'd0, start_click}, 0);
    end
    MOUSE_LEFT = 1'b0; tick();
    chk("sc_pulse", {31'd0, start_click}, 1);
    tick();
    chk("sc_one_cycle", {31'd0, start_click}, 0);

    // drag off the button before release
    MOUSE_LEFT = 1'b1; tick();
    mouse_y = 300; tick(); tick();
    MOUSE_LEFT = 1'b0; tick();
    chk("drag_no_click", {31'd0, start_click}, 0);
    tick();
    chk("drag_no_click2", {31'd0, start_click}, 0);
    click(300, 250);
    chk("drag_then_click", {31'd0, start_click}, 1);

    // 10-cycle glitch on link_in must be filtered
    link_in = 1'b1;
    repeat (10) tick();
    link_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("glitch_rcv", {31'd0, receive_connect}, 0);
    end

    // timeout: SENDING for 50 cycles with no partner
    click(300, 350); tick();
    chk("tmo_snd_on", {31'd0, send_connect}, 1);
    chk("tmo_lo_on", {31'd0, link_out}, 1);
    chk("tmo_up_off", {31'd0, link_up}, 0);
    repeat (48) tick();
    chk("tmo_snd_48", {31'd0, send_connect}, 1);
    tick();
    chk("tmo_snd_49", {31'd0, send_connect}, 1);
    tick();
    chk("tmo_snd_50", {31'd0, send_connect}, 0);
    chk("tmo_lo_50", {31'd0, link_out}, 0);

    // cancel from SENDING with a second connect click
    click(300, 350); tick();
    chk("cancel_snd_on", {31'd0, send_connect}, 1);
    click(300, 350); tick();
    chk("cancel_snd_off", {31'd0, send_connect}, 0);

    // handshake: receive_connect 18 edges after link_in, link_up one cycle later
    click(300, 350); tick();
    link_in = 1'b1;
    repeat (17) tick();
    chk("hs_rcv_17", {31'd0, receive_connect}, 0);
    tick();
    chk("hs_rcv_18", {31'd0, receive_connect}, 1);
    chk("hs_up_18", {31'd0, link_up}, 0);
    tick();
    chk("hs_up", {31'd0, link_up}, 1);
    chk("hs_snd", {31'd0, send_connect}, 1);
    chk("hs_lo", {31'd0, link_out}, 1);
    link_in = 1'b0;
    repeat (17) tick();
    chk("drop_rcv_17", {31'd0, receive_connect}, 1);
    tick();
    chk("drop_rcv_18", {31'd0, receive_connect}, 0);
    chk("drop_up_18", {31'd0, link_up}, 1);
    tick();
    chk("drop_up", {31'd0, link_up}, 0);
    chk("drop_snd", {31'd0, send_connect}, 1);

    // conn_click and receive_connect rising together: cancel wins
    link_in = 1'b1; MOUSE_LEFT = 1'b1;
    tick();
    repeat (16) tick();
    MOUSE_LEFT = 1'b0; tick();
    chk("simul_rcv", {31'd0, receive_connect}, 1);
    tick();
    chk("simul_snd", {31'd0, send_connect}, 0);
    chk("simul_up", {31'd0, link_up}, 0);

    // asynchronous reset while CONNECTED
    click(300, 350); tick(); tick();
    chk("pre_rst_up", {31'd0, link_up}, 1);
    #2 rst = 1'b1;
    #1 all_zero("rst_conn");
    link_in = 1'b0; rst = 1'b0;
    tick();

    // asynchronous reset during a held press on Start
    mouse_x = 300; mouse_y = 250; tick();
    MOUSE_LEFT = 1'b1; tick(); tick();
    #2 rst = 1'b1;
    #1 all_zero("rst_press");
    rst = 1'b0;
    tick(); tick();
    MOUSE_LEFT = 1'b0; tick();
    chk("post_rst_no_click", {31'd0, start_click}, 0);
    tick();
    chk("post_rst_no_click2", {31'd0, start_click}, 0);
    click(300, 250);
    chk("post_rst_fresh_click", {31'd0, start_click}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
